// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 8-digit packed BCD converter (double dabble).
// One bit per cycle: a start accepted at edge k completes with a one-cycle
// o_done pulse after edge k+32. Operands above 99_999_999 raise o_ovf.
// Optional feature macro: BIN2BCD_SAT_EN -- when defined, an overflowing
// operand yields 32'h99999999 instead of the modulo-10^8 result.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_bin,
  output logic [31:0] o_bcd,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ovf
);

  localparam logic [31:0] MaxDec = 32'd99_999_999;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic [31:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic [31:0] adj;
  logic [31:0] acc_step;

  // One double-dabble step: correct digits >= 5, then shift in the operand MSB.
  // The bit leaving acc bit 31 is dropped, which makes the result modulo 10^8.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 8; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_step = {adj[30:0], bin_q[31]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          bin_d      = i_bin;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (i_bin > MaxDec);
          state_d    = StShift;
        end
      end
      StShift: begin
        acc_d = acc_step;
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StIdle;
          done_d  = 1'b1;
          ovf_d   = ovf_pend_q;
`ifdef BIN2BCD_SAT_EN
          bcd_d   = ovf_pend_q ? 32'h9999_9999 : acc_step;
`else
          bcd_d   = acc_step;
`endif
        end
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign o_bcd  = bcd_q;
  assign o_ovf  = ovf_q;
  assign o_done = done_q;
  assign o_busy = (state_q == StShift);

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock and reset is the only reset.
REQ-002 Port clk SHALL be: clk, input, 1, rising-edge clock for all state.
REQ-003 Port reset SHALL be: reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port i_start SHALL be: i_start, input, 1, conversion request, sampled every cycle.
REQ-005 Port i_bin SHALL be: i_bin, input, 32, unsigned binary operand, captured when a start is accepted.
REQ-006 Port o_bcd SHALL be: o_bcd, output, 32, eight packed BCD digits, digit 0 at [3:0] and digit 7 at [31:28], formatted to feed the 8-digit display driver directly.
REQ-007 Port o_busy SHALL be: o_busy, output, 1, high while a conversion is in progress.
REQ-008 Port o_done SHALL be: o_done, output, 1, single-cycle pulse marking that o_bcd and o_ovf have just been updated.
REQ-009 Port o_ovf SHALL be: o_ovf, output, 1, high when the last converted operand was greater than 99_999_999 (32'h05F5E0FF).

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and SHIFT.
REQ-011 In IDLE with i_start=1, the block SHALL capture i_bin into an internal shift register, clear the 32-bit BCD accumulator, clear the 5-bit shift counter, and enter SHIFT.
REQ-012 Each SHIFT cycle SHALL perform one double-dabble step, in this order:
- add 3 to every accumulator digit that is >= 5;
- shift {accumulator, operand} left by one bit;
- discard the bit shifted out of accumulator bit 31.
REQ-013 SHIFT SHALL last exactly 32 cycles; on the 32nd SHIFT edge the block SHALL load the final accumulator into o_bcd, set o_done=1 and return to IDLE.
REQ-014 Latency SHALL be fixed: if a start is accepted at edge k, o_done is high for the single cycle following edge k+32, and o_bcd/o_ovf are valid from that same cycle.
REQ-015 o_busy SHALL be 1 exactly while the state is SHIFT (the cycles following edges k through k+31) and 0 in the o_done cycle.
REQ-016 i_start SHALL be ignored while o_busy=1; no queueing.
REQ-017 i_start high in the o_done cycle SHALL be accepted, allowing back-to-back conversions every 33 cycles.
REQ-018 o_ovf SHALL be computed from the captured operand at accept time and presented together with o_bcd at o_done.
REQ-019 o_bcd and o_ovf SHALL hold their last values until the next completion.
REQ-020 o_done SHALL be 0 in all other cycles.
REQ-021 Without saturation, o_bcd SHALL equal the operand modulo 100_000_000, since the top carry is discarded.

Reset
REQ-022 While reset=1 at a clock edge, the block SHALL set state=IDLE, counter=0, o_bcd=32'h0, o_busy=0, o_done=0 and o_ovf=0.
REQ-023 Reset SHALL take priority over i_start.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion with no o_done pulse and no update to o_bcd.

Configuration
REQ-025 The macro BIN2BCD_SAT_EN SHALL select overflow handling:
- defined: when o_ovf=1 at completion, o_bcd SHALL be forced to 32'h99999999;
- undefined: o_bcd SHALL be the modulo-10^8 result per REQ-021.
REQ-026 o_ovf behaviour and conversion latency SHALL be identical with and without BIN2BCD_SAT_EN.

Verification
REQ-027 Reset: assert reset for 2 cycles -> o_bcd=32'h0, o_busy=0, o_done=0, o_ovf=0.
REQ-028 Nominal conversion: i_bin=32'd12345678, pulse i_start -> o_done exactly 33 cycles after the accept edge, o_bcd=32'h12345678, o_ovf=0.
REQ-029 Boundary values:
- i_bin=32'd99999999 -> o_bcd=32'h99999999, o_ovf=0;
- i_bin=32'd100000000 -> o_ovf=1, o_bcd=32'h99999999 with BIN2BCD_SAT_EN, 32'h00000000 without.
REQ-030 Maximum operand: i_bin=32'hFFFFFFFF (4294967295) -> o_ovf=1, o_bcd=32'h94967295 without BIN2BCD_SAT_EN, 32'h99999999 with it.
REQ-031 Handshake:
- i_start held high throughout a conversion of 32'd7 with i_bin changed to 32'd5 mid-run -> single result 32'h00000007;
- the i_start still high in the o_done cycle starts a second conversion -> 32'h00000005 exactly 33 cycles later.
REQ-032 Abort: reset asserted at the 10th SHIFT cycle -> no o_done pulse, outputs at reset values, and a subsequent i_bin=32'd42 start yields 32'h00000042.
